// File: rtl/modsq_carry_resolve.sv
// Word-serial carry resolver: folds redundant 17-bit coefficients into canonical
// 16-bit words, one coefficient per cycle, and holds the result for a valid/ready reader.
module modsq_carry_resolve #(
  parameter int MOD_LEN               = 1024,
  parameter int WORD_LEN              = 16,
  parameter int REDUNDANT_ELEMENTS    = 2,
  parameter int NONREDUNDANT_ELEMENTS = MOD_LEN / WORD_LEN,
  parameter int NUM_ELEMENTS          = REDUNDANT_ELEMENTS + NONREDUNDANT_ELEMENTS,
  parameter int BIT_LEN               = 17,
  parameter int SLOT_BITS             = 2 * WORD_LEN
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [NUM_ELEMENTS*SLOT_BITS-1:0] sq_in,
  output logic                             busy,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_ELEMENTS*WORD_LEN-1:0] result,
  output logic [1:0]                       carry_out,
  output logic                             coef_err,
  output logic                             overrun
);

  localparam int IDX_W = $clog2(NUM_ELEMENTS + 1);
  localparam int ACC_W = BIT_LEN + 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                            state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [1:0]                        carry_q, carry_d;
  logic [NUM_ELEMENTS*BIT_LEN-1:0]   coef_q, coef_d;
  logic [NUM_ELEMENTS*WORD_LEN-1:0]  result_q, result_d;
  logic [1:0]                        carry_out_q, carry_out_d;
  logic                              busy_q, busy_d;
  logic                              out_valid_q, out_valid_d;
  logic                              coef_err_q, coef_err_d;
  logic                              overrun_q, overrun_d;

  logic [NUM_ELEMENTS*BIT_LEN-1:0]   capture_coef;
  logic                              slot_hi_err;
  logic                              start;
  logic [ACC_W-1:0]                  acc;

  always_comb begin
    capture_coef = '0;
    slot_hi_err  = 1'b0;
    for (int j = 0; j < NUM_ELEMENTS; j++) begin
      capture_coef[j*BIT_LEN +: BIT_LEN] = sq_in[j*SLOT_BITS +: BIT_LEN];
      slot_hi_err = slot_hi_err | (|sq_in[j*SLOT_BITS+BIT_LEN +: SLOT_BITS-BIT_LEN]);
    end
  end

  // A finishing RUN step after the last coefficient latches carry_out, giving
  // out_valid NUM_ELEMENTS+1 cycles after capture.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    coef_d      = coef_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    coef_err_d  = coef_err_q;
    overrun_d   = 1'b0;
    acc         = '0;
    start       = 1'b0;

    case (state_q)
      IDLE: begin
        start = in_valid;
      end
      RUN: begin
        overrun_d = in_valid;
        if (idx_q == IDX_W'(NUM_ELEMENTS)) begin
          carry_out_d = carry_q;
          state_d     = HOLD;
        end else begin
          acc = {1'b0, coef_q[idx_q*BIT_LEN +: BIT_LEN]} + ACC_W'(carry_q);
          result_d[idx_q*WORD_LEN +: WORD_LEN] = acc[WORD_LEN-1:0];
          carry_d = acc[WORD_LEN +: 2];
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          start   = in_valid;
        end else begin
          overrun_d = in_valid;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      coef_d     = capture_coef;
      coef_err_d = coef_err_q | slot_hi_err;
      idx_d      = '0;
      carry_d    = '0;
      state_d    = RUN;
    end

    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= '0;
      coef_q      <= '0;
      result_q    <= '0;
      carry_out_q <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      coef_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      coef_q      <= coef_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      coef_err_q  <= coef_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign coef_err  = coef_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_modsq_carry_resolve.sv
// Scoreboard bench for modsq_carry_resolve: the driver pushes expected results from a
// whole-integer reference model; a negedge monitor pops and compares on each out_valid.
module tb_modsq_carry_resolve;

  localparam int NUM  = 66;
  localparam int W    = 16;
  localparam int SLOT = 32;
  localparam int BL   = 17;
  localparam int LAT  = NUM + 1;
  localparam int TOTW = NUM * W + 2;

  typedef struct {
    logic [NUM*W-1:0] res;
    logic [1:0]       cy;
    logic             err;
    int               launch;
  } exp_t;

  logic                 clk;
  logic                 reset;
  logic                 in_valid;
  logic [NUM*SLOT-1:0]  sq_in;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [NUM*W-1:0]     result;
  logic [1:0]           carry_out;
  logic                 coef_err;
  logic                 overrun;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  int   ovr_q[$];
  bit   exp_err = 0;
  exp_t cur;
  bit   have_cur = 0;
  logic ov_prev  = 0;

  modsq_carry_resolve dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .sq_in     (sq_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .coef_err  (coef_err),
    .overrun   (overrun)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // The canonical value is simply the integer sum of truncated coefficients at weight 2^(16j).
  function automatic void refModel(input logic [NUM*SLOT-1:0] data, output logic [NUM*W-1:0] res,
                                   output logic [1:0] cy, output bit bad);
    logic [TOTW-1:0] total, term;
    logic [SLOT-1:0] s;
    total = '0;
    bad   = 0;
    for (int j = 0; j < NUM; j++) begin
      s = data[j*SLOT +: SLOT];
      if (s[SLOT-1:BL] != '0) bad = 1;
      term = '0;
      term[BL-1:0] = s[BL-1:0];
      total = total + (term << (W * j));
    end
    res = total[NUM*W-1:0];
    cy  = total[NUM*W +: 2];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic checkResult(input string name, input logic [NUM*W-1:0] act, input logic [NUM*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int j = 0; j < NUM; j++) begin
        if (act[j*W +: W] !== exp[j*W +: W]) begin
          $display("[TB] FAIL %s: word %0d actual %h required %h at cycle %0d",
                   name, j, act[j*W +: W], exp[j*W +: W], cyc);
          break;
        end
      end
    end
  endtask

  // Called just after a negedge; drives a one-cycle in_valid pulse and records what should follow.
  task automatic applyStimulus(input logic [NUM*SLOT-1:0] data, input bit accept);
    exp_t e;
    bit   bad;
    in_valid = 1;
    sq_in    = data;
    if (accept) begin
      refModel(data, e.res, e.cy, bad);
      if (bad) exp_err = 1;
      e.err    = exp_err;
      e.launch = cyc + 1;
      sb.push_back(e);
    end else begin
      ovr_q.push_back(cyc + 1);
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic waitOutValid(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL out_valid_timeout: actual 0 required 1 after %0d cycles", budget);
    end
  endtask

  task automatic runOne(input logic [NUM*SLOT-1:0] data);
    applyStimulus(data, 1);
    waitOutValid(200);
    @(negedge clk);
    checkOutput("out_valid_single_cycle", out_valid, 0);
    checkOutput("busy_after_accept", busy, 0);
  endtask

  function automatic logic [NUM*SLOT-1:0] randData(input bit allow_hi);
    logic [NUM*SLOT-1:0] d;
    for (int j = 0; j < NUM; j++)
      d[j*SLOT +: SLOT] = allow_hi ? $urandom : $urandom_range(32'h1FFFF, 0);
    return d;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_out_valid: actual 1 required 0 at cycle %0d", cyc);
          have_cur = 0;
        end else begin
          cur = sb.pop_front();
          have_cur = 1;
          checkOutput("latency", 64'(cyc - cur.launch), 64'(LAT));
          checkResult("result", result, cur.res);
          checkOutput("carry_out", carry_out, cur.cy);
          checkOutput("coef_err", coef_err, cur.err);
        end
      end else if (out_valid && have_cur) begin
        checkResult("hold_result", result, cur.res);
        checkOutput("hold_carry_out", carry_out, cur.cy);
      end
      if (overrun) begin
        if (ovr_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_overrun: actual 1 required 0 at cycle %0d", cyc);
        end else begin
          checkOutput("overrun_cycle", 64'(cyc), 64'(ovr_q.pop_front()));
        end
      end
    end
    ov_prev = out_valid;
  end

  initial begin
    logic [NUM*SLOT-1:0] d;
    reset     = 0;
    in_valid  = 0;
    out_ready = 1;
    sq_in     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkResult("reset_result", result, '0);
    checkOutput("reset_carry_out", carry_out, 0);
    checkOutput("reset_coef_err", coef_err, 0);
    checkOutput("reset_overrun", overrun, 0);
    reset = 1;
    @(negedge clk);

    $display("[TB] all-zero run");
    runOne('0);

    $display("[TB] slot0 = 0x1FFFF");
    d = '0;
    d[0 +: SLOT] = 32'h0001_FFFF;
    runOne(d);

    $display("[TB] all slots = 0x1FFFF");
    for (int j = 0; j < NUM; j++) d[j*SLOT +: SLOT] = 32'h0001_FFFF;
    runOne(d);
    checkOutput("all_max_carry_const", cur.cy, 2);

    $display("[TB] random in-range runs");
    for (int r = 0; r < 5; r++) runOne(randData(0));

    $display("[TB] out-of-range slot sets sticky coef_err");
    d = '0;
    d[3*SLOT +: SLOT] = 32'h0002_0005;
    runOne(d);
    runOne('0);
    checkOutput("coef_err_sticky", coef_err, 1);
    for (int r = 0; r < 2; r++) runOne(randData(1));

    $display("[TB] backpressure with overruns");
    out_ready = 0;
    applyStimulus(randData(0), 1);
    repeat (4) @(negedge clk);
    applyStimulus(randData(1), 0);
    waitOutValid(200);
    repeat (2) @(negedge clk);
    applyStimulus(randData(1), 0);
    repeat (6) @(negedge clk);
    checkOutput("hold_out_valid", out_valid, 1);
    out_ready = 1;
    applyStimulus(randData(0), 1);
    checkOutput("busy_after_simultaneous", busy, 1);
    waitOutValid(200);
    @(negedge clk);
    checkOutput("out_valid_drop", out_valid, 0);

    $display("[TB] reset during RUN");
    applyStimulus(randData(0), 1);
    repeat (19) @(negedge clk);
    reset = 0;
    sb.delete();
    exp_err = 0;
    @(negedge clk);
    checkOutput("midrun_reset_busy", busy, 0);
    checkOutput("midrun_reset_out_valid", out_valid, 0);
    checkResult("midrun_reset_result", result, '0);
    checkOutput("midrun_reset_coef_err", coef_err, 0);
    reset = 1;
    @(negedge clk);
    applyStimulus(randData(0), 1);
    repeat (2) @(negedge clk);
    applyStimulus(randData(1), 0);
    waitOutValid(200);
    @(negedge clk);
    checkOutput("post_reset_coef_err", coef_err, 0);
    checkOutput("post_reset_out_valid", out_valid, 0);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(sb.size()), 0);
    checkOutput("overrun_drained", 64'(ovr_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
